// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: FSM encoding, command bytes, frame geometry, parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StSend,
    StAck,
    StWaitIdle
  } state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // Host frame: start, 8 data, parity, stop, then the device's ACK bit.
  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;
  // Index of the stop bit counted from the first device falling edge.
  localparam logic [3:0] PS2_STOP_IDX    = 4'd9;

  // Odd parity: the parity bit makes the total count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data lines plus a falling-edge strobe on clock.
module ps2_host_tx_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic sync_clk,
  output logic sync_dat,
  output logic fe
);

  logic clk_meta_q, clk_sync_q, clk_dly_q;
  logic dat_meta_q, dat_sync_q;

  // Synchroniser chains; reset to 1 so an idle (pulled-up) bus never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_dly_q  <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_dly_q  <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Outputs: synced levels and a one-cycle strobe on a high-to-low clock transition.
  always_comb begin
    sync_clk = clk_sync_q;
    sync_dat = dat_sync_q;
    fe       = clk_dly_q & ~clk_sync_q;
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
// Drives open-drain pull-down enables only; tristates are built at the top level.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2600,
  parameter int unsigned TIMEOUT_CYCLES = 400000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [WdW-1:0]  WdTerm  = WdW'(TIMEOUT_CYCLES);

  logic sync_clk, sync_dat, fe;

  ps2_host_tx_line_sync u_line_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .sync_clk   (sync_clk),
    .sync_dat   (sync_dat),
    .fe         (fe)
  );

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [8:0]      shift_q, shift_d;      // {parity, data}
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            ack_res_q, ack_res_d;
  logic            done_q, done_d;
  logic            ack_ok_q, ack_ok_d;
  logic            error_q, error_d;
  logic            wdog_live;

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      inh_cnt_q <= '0;
      wdog_q    <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ack_res_q <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      inh_cnt_q <= inh_cnt_d;
      wdog_q    <= wdog_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ack_res_q <= ack_res_d;
      done_q    <= done_d;
      ack_ok_q  <= ack_ok_d;
      error_q   <= error_d;
    end
  end

  // Next-state, line drive and result logic; watchdog expiry overrides everything.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    inh_cnt_d = inh_cnt_q;
    wdog_d    = wdog_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    ack_res_d = ack_res_q;
    done_d    = 1'b0;
    ack_ok_d  = 1'b0;
    error_d   = 1'b0;

    wdog_live = (state_q == StRts) || (state_q == StSend) ||
                (state_q == StAck) || (state_q == StWaitIdle);
    if (wdog_live) begin
      if (fe) begin
        wdog_d = '0;
      end else if (wdog_q != WdTerm) begin
        wdog_d = wdog_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d   = {odd_parity(tx_data), tx_data};
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        // Pull data low while clock is still held so both lines are never released together.
        if (inh_cnt_q == InhLast) begin
          dat_oe_d = 1'b1;
          wdog_d   = '0;
          state_d  = StRts;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      StRts: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b1;
        // First device edge already clocks out data bit 0.
        if (fe) begin
          dat_oe_d  = ~shift_q[0];
          bit_cnt_d = 4'd1;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (fe) begin
          if (bit_cnt_q == PS2_STOP_IDX) begin
            dat_oe_d = 1'b0;
            state_d  = StAck;
          end else begin
            dat_oe_d  = ~shift_q[bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StAck: begin
        if (fe) begin
          ack_res_d = ~sync_dat;
          state_d   = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (sync_clk && sync_dat) begin
          done_d   = 1'b1;
          ack_ok_d = ack_res_q;
          error_d  = ~ack_res_q;
          state_d  = StIdle;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = StIdle;
      end
    endcase

    if (wdog_live && (wdog_q == WdTerm)) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      done_d   = 1'b1;
      ack_ok_d = 1'b0;
      error_d  = 1'b1;
      state_d  = StIdle;
    end
  end

  // Outputs straight from registers so the bus lines cannot glitch.
  always_comb begin
    ps2_clk_oe = clk_oe_q;
    ps2_dat_oe = dat_oe_q;
    tx_ready   = (state_q == StIdle);
    busy       = (state_q != StIdle);
    done       = done_q;
    ack_ok     = ack_ok_q;
    error      = error_q;
  end

endmodule
